// File: rtl/conv_mask_pkg.sv
// Shared types and constants for the 4x4 convolution-mask coefficient sequencer.
// Maps each raster cell of the kernel to one of nine region weights and its area shift.
package conv_mask_pkg;

  localparam int WEIGHT_W = 16;

  typedef enum logic [1:0] {
    CORNER = 2'd0,
    EDGE   = 2'd1,
    CENTRE = 2'd2
  } cell_class_e;

  // Right-shift amount equals log2 of the region area in cells.
  localparam logic [1:0] SHIFT_CORNER = 2'd0;
  localparam logic [1:0] SHIFT_EDGE   = 2'd1;
  localparam logic [1:0] SHIFT_CENTRE = 2'd2;

  // Region index: 0 centre, 1..4 edges (top, right, bottom, left), 5..8 corners (cells 0, 3, 12, 15).
  localparam logic [15:0][3:0] CELL_REGION = {
    4'd8, 4'd3, 4'd3, 4'd7,   // cells 15..12
    4'd2, 4'd0, 4'd0, 4'd4,   // cells 11..8
    4'd2, 4'd0, 4'd0, 4'd4,   // cells  7..4
    4'd6, 4'd1, 4'd1, 4'd5    // cells  3..0
  };

  function automatic cell_class_e region_class(input logic [3:0] region);
    if (region == 4'd0)      return CENTRE;
    else if (region <= 4'd4) return EDGE;
    else                     return CORNER;
  endfunction

  function automatic logic [1:0] class_shift(input cell_class_e cls);
    case (cls)
      CENTRE:  return SHIFT_CENTRE;
      EDGE:    return SHIFT_EDGE;
      default: return SHIFT_CORNER;
    endcase
  endfunction

endpackage

// File: rtl/conv_mask4x4_seq_if.sv
// Weight/enable inputs and coefficient outputs of the mask sequencer, bundled as one interface.
interface conv_mask4x4_seq_if #(
  parameter int WEIGHT_W = 16
);
  logic                dataEn;
  logic [WEIGHT_W-1:0] pix_4_weight;
  logic [WEIGHT_W-1:0] pix_2_weight1;
  logic [WEIGHT_W-1:0] pix_2_weight2;
  logic [WEIGHT_W-1:0] pix_2_weight3;
  logic [WEIGHT_W-1:0] pix_2_weight4;
  logic [WEIGHT_W-1:0] pix_1_weight1;
  logic [WEIGHT_W-1:0] pix_1_weight2;
  logic [WEIGHT_W-1:0] pix_1_weight3;
  logic [WEIGHT_W-1:0] pix_1_weight4;
  logic [WEIGHT_W-1:0] Dout;
  logic                Dout_vld;
  logic                mask_last;

  modport master (
    output dataEn, pix_4_weight,
           pix_2_weight1, pix_2_weight2, pix_2_weight3, pix_2_weight4,
           pix_1_weight1, pix_1_weight2, pix_1_weight3, pix_1_weight4,
    input  Dout, Dout_vld, mask_last
  );

  modport slave (
    input  dataEn, pix_4_weight,
           pix_2_weight1, pix_2_weight2, pix_2_weight3, pix_2_weight4,
           pix_1_weight1, pix_1_weight2, pix_1_weight3, pix_1_weight4,
    output Dout, Dout_vld, mask_last
  );
endinterface

// File: rtl/conv_mask_cell_sel.sv
// Combinational lookup: raster cell index -> region weight and its area shift.
module conv_mask_cell_sel
  import conv_mask_pkg::*;
#(
  parameter int W = WEIGHT_W
) (
  input  logic [3:0]        cell_i,
  input  logic [8:0][W-1:0] weights_i,
  output logic [W-1:0]      weight_o,
  output logic [1:0]        shift_o
);
  logic [3:0]  region;
  cell_class_e cls;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    region   = CELL_REGION[cell_i];
    cls      = region_class(region);
    weight_o = '0;
    shift_o  = class_shift(cls);
    if (region <= 4'd8) weight_o = weights_i[region];
  end
endmodule

// File: rtl/conv_mask4x4_seq.sv
// 4x4 mask coefficient sequencer: one per-cell coefficient (region weight / area) per enabled cycle.
// Build option CONV_MASK_ROUND_EN selects round-half-up division instead of floor.
module conv_mask4x4_seq
  import conv_mask_pkg::*;
#(
  parameter int WEIGHT_W = conv_mask_pkg::WEIGHT_W
) (
  input  logic isp_clk,
  input  logic rst_n,
  conv_mask4x4_seq_if.slave bus
);
  logic [3:0]          cnt_q, cnt_d;
  logic [WEIGHT_W-1:0] dout_q, dout_d;
  logic                vld_q, vld_d;
  logic                last_q, last_d;

  logic [8:0][WEIGHT_W-1:0] weights;
  logic [WEIGHT_W-1:0]      sel_weight;
  logic [1:0]               sel_shift;
  logic signed [WEIGHT_W:0] w_ext;
  logic signed [WEIGHT_W:0] w_div;

  assign weights = {bus.pix_1_weight4, bus.pix_1_weight3, bus.pix_1_weight2, bus.pix_1_weight1,
                    bus.pix_2_weight4, bus.pix_2_weight3, bus.pix_2_weight2, bus.pix_2_weight1,
                    bus.pix_4_weight};

  conv_mask_cell_sel #(.W(WEIGHT_W)) u_cell_sel (
    .cell_i   (cnt_q),
    .weights_i(weights),
    .weight_o (sel_weight),
    .shift_o  (sel_shift)
  );

  // One guard bit keeps the rounding increment from overflowing near the positive limit.
  always_comb begin
    w_ext = $signed({sel_weight[WEIGHT_W-1], sel_weight});
`ifdef CONV_MASK_ROUND_EN
    if (sel_shift != 2'd0)
      w_ext = w_ext + ((WEIGHT_W+1)'(1) << (sel_shift - 2'd1));
`endif
    w_div = w_ext >>> sel_shift;
  end

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    last_d = 1'b0;
    if (bus.dataEn) begin
      cnt_d  = cnt_q + 4'd1;
      dout_d = w_div[WEIGHT_W-1:0];
      vld_d  = 1'b1;
      last_d = (cnt_q == 4'd15);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; this reset is synchronous and active-high.
  always_ff @(posedge isp_clk) begin
    if (rst_n) begin
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign bus.Dout      = dout_q;
  assign bus.Dout_vld  = vld_q;
  assign bus.mask_last = last_q;
endmodule

// File: tb/tb_conv_mask4x4_seq.sv
// Directed self-checking bench for conv_mask4x4_seq: table-driven mask pass plus gap, odd-weight
// rounding and mid-mask reset sequences.
module tb_conv_mask4x4_seq;
  localparam int W = 16;

  logic isp_clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  conv_mask4x4_seq_if #(.WEIGHT_W(W)) bus ();

  conv_mask4x4_seq #(.WEIGHT_W(W)) dut (
    .isp_clk(isp_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 isp_clk = ~isp_clk;

  typedef struct {
    logic         en;
    logic [W-1:0] exp_dout;
    logic         exp_vld;
    logic         exp_last;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge isp_clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [W-1:0] d, input logic v, input logic l);
    check({name, ".dout"}, 32'(bus.Dout), 32'(d));
    check({name, ".vld"},  32'(bus.Dout_vld), 32'(v));
    check({name, ".last"}, 32'(bus.mask_last), 32'(l));
  endtask

  task automatic set_weights(input logic [W-1:0] w4, input logic [W-1:0] w2, input logic [W-1:0] w1);
    bus.pix_4_weight  = w4;
    bus.pix_2_weight1 = w2; bus.pix_2_weight2 = w2;
    bus.pix_2_weight3 = w2; bus.pix_2_weight4 = w2;
    bus.pix_1_weight1 = w1; bus.pix_1_weight2 = w1;
    bus.pix_1_weight3 = w1; bus.pix_1_weight4 = w1;
  endtask

  initial begin
    logic [W-1:0] cell_exp [16];
    logic [W-1:0] sum;
    logic [W-1:0] exp_c1;

    cell_exp = '{16'h0000, 16'hFFF8, 16'hFFF8, 16'h0000,
                 16'hFFF8, 16'hFFFC, 16'hFFFC, 16'hFFF8,
                 16'hFFF8, 16'hFFFC, 16'hFFFC, 16'hFFF8,
                 16'h0000, 16'hFFF8, 16'hFFF8, 16'h0000};
    for (int i = 0; i < 16; i++)
      vecs[i] = '{en: 1'b1, exp_dout: cell_exp[i], exp_vld: 1'b1, exp_last: (i == 15)};
    vecs[16] = '{en: 1'b1, exp_dout: cell_exp[0], exp_vld: 1'b1, exp_last: 1'b0};

    // Reset held two cycles with enable high.
    rst_n = 1'b1;
    bus.dataEn = 1'b1;
    set_weights(16'hFFF0, 16'hFFF0, 16'h0000);
    step();
    step();
    check_out("reset", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b0;

    // Full mask then wrap to cell 0.
    sum = '0;
    for (int i = 0; i < 17; i++) begin
      bus.dataEn = vecs[i].en;
      step();
      check_out($sformatf("cell%0d", i), vecs[i].exp_dout, vecs[i].exp_vld, vecs[i].exp_last);
      if (i < 16) sum = sum + bus.Dout;
    end
    check("mask_sum", 32'(sum), 32'h0000FFB0);

    // Cells 1..6, then a 3-cycle gap, then resume with cell 7.
    for (int i = 1; i <= 6; i++) step();
    check_out("pre_gap_cell6", 16'hFFFC, 1'b1, 1'b0);
    bus.dataEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("gap%0d", i), 16'hFFFC, 1'b0, 1'b0);
    end
    bus.dataEn = 1'b1;
    step();
    check_out("resume_cell7", 16'hFFF8, 1'b1, 1'b0);

    // Odd weights: floor vs round-half-up.
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    set_weights(16'hFFFD, 16'hFFF0, 16'h0000);
    bus.pix_2_weight1 = 16'h0003;
`ifdef CONV_MASK_ROUND_EN
    exp_c1 = 16'h0002;
`else
    exp_c1 = 16'h0001;
`endif
    for (int i = 0; i <= 5; i++) begin
      step();
      if (i == 1) check("odd_cell1", 32'(bus.Dout), 32'(exp_c1));
      if (i == 5) check("odd_cell5", 32'(bus.Dout), 32'h0000FFFF);
    end

    // Reset asserted when cell 9 would be emitted; next enabled output is cell 0.
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    set_weights(16'hFFF0, 16'hFFF0, 16'h0000);
    bus.pix_1_weight1 = 16'h1234;
    for (int i = 0; i < 9; i++) step();
    check("pre_reset_cell8", 32'(bus.Dout), 32'h0000FFF8);
    rst_n = 1'b1;
    step();
    check_out("midreset", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    check_out("post_reset_cell0", 16'h1234, 1'b1, 1'b0);
    step();
    check("post_reset_cell1", 32'(bus.Dout), 32'h0000FFF8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
